adc_reader: RTL

ADC_READER -- requirements
Module: adc_reader

---
 rtl/adc_reader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/adc_reader.sv
// Periodic serial ADC reader: a free-running period counter launches one
// 16-SCLK conversion frame and publishes the 10-bit result with a newSample flag.
module adc_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 1250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       channel,
  input  logic       adcMiso,
  output logic       adcSclk,
  output logic       adcMosi,
  output logic       adcCs,
  output logic [9:0] sampleVoltage,
  output logic       newSample
);

  // state | meaning
  // IDLE  | chip select high, waiting for a period tick with enable set
  // SHIFT | frame in progress, 16 SCLK periods of H low + H high cycles
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam int              PW          = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PW-1:0]   PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]      HALF_LOAD   = 8'(CLK_DIV - 1);
  localparam logic [3:0]      LAST_BIT    = 4'd15;
  localparam logic [3:0]      FIRST_DATA  = 4'd6;

  logic [PW-1:0] period_cnt;
  logic          tick;
  logic [0:0]    state;
  logic [7:0]    half_cnt;
  logic [3:0]    bit_idx;
  logic          ch_lat;
  logic [9:0]    shift_reg;
  logic          load_done;

  // Command word: start, single-ended, channel, MSB-first, then zeros.
  function automatic logic mosi_bit(input logic [3:0] k, input logic ch);
    logic b;
    case (k)
      4'd0, 4'd1, 4'd3: b = 1'b1;
      4'd2:             b = ch;
      default:          b = 1'b0;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
    end else if (period_cnt == PERIOD_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  assign tick = (period_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      adcCs         <= 1'b1;
      adcSclk       <= 1'b0;
      adcMosi       <= 1'b0;
      sampleVoltage <= '0;
      newSample     <= 1'b0;
      half_cnt      <= '0;
      bit_idx       <= '0;
      ch_lat        <= 1'b0;
      shift_reg     <= '0;
      load_done     <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && enable) begin
            state     <= SHIFT;
            adcCs     <= 1'b0;
            adcSclk   <= 1'b0;
            adcMosi   <= mosi_bit(4'd0, channel);
            ch_lat    <= channel;
            half_cnt  <= HALF_LOAD;
            bit_idx   <= '0;
            shift_reg <= '0;
            newSample <= 1'b0;
          end else if (load_done) begin
            newSample <= 1'b1;
          end
        end
        SHIFT: begin
          // Ticks arriving here are deliberately ignored; the frame always runs to the end.
          if (half_cnt != 8'd0) begin
            half_cnt <= half_cnt - 8'd1;
          end else begin
            half_cnt <= HALF_LOAD;
            if (!adcSclk) begin
              adcSclk <= 1'b1;
              if (bit_idx >= FIRST_DATA) begin
                shift_reg <= {shift_reg[8:0], adcMiso};
              end
            end else begin
              adcSclk <= 1'b0;
              if (bit_idx == LAST_BIT) begin
                state         <= IDLE;
                adcCs         <= 1'b1;
                adcMosi       <= 1'b0;
                sampleVoltage <= shift_reg;
                load_done     <= 1'b1;
              end else begin
                bit_idx <= bit_idx + 4'd1;
                adcMosi <= mosi_bit(bit_idx + 4'd1, ch_lat);
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          adcCs <= 1'b1;
        end
      endcase
    end
  end

endmodule
